// File: rtl/fft_size_ctrl.sv
// Size-select sequencer for the 8/16/32-point radix-2 engines behind the OR-combining output mux.
// Optional done-timeout supervision is compiled in with `define FFT_CTRL_TIMEOUT_EN.
module fft_size_ctrl #(
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned TMO_W      = 8,
  parameter int unsigned TMO_CYCLES = 200
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             req_valid_i,
  input  logic [1:0]       req_size_i,
  output logic             req_ready_o,
  output logic             start8_o,
  output logic             start16_o,
  output logic             start32_o,
  input  logic             done8_i,
  input  logic             done16_i,
  input  logic             done32_i,
  output logic             oe8_o,
  output logic             oe16_o,
  output logic             oe32_o,
  output logic             res_valid_o,
  input  logic             res_ready_i,
  output logic [1:0]       res_size_o,
  output logic             busy_o,
  output logic             err_o,
  output logic [CNT_W-1:0] frame_cnt_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    HOLD  = 2'd3
  } state_t;

  state_t     state;
  logic [1:0] size_q;
  logic       sel_done_c;

`ifdef FFT_CTRL_TIMEOUT_EN
  logic [TMO_W-1:0] tmo_q;
`else
  // Timeout parameters have no function without the supervision logic.
  logic unused_tmo;
  assign unused_tmo = ^TMO_W'(TMO_CYCLES);
`endif

  // Completion from the engine that was actually started; the others are ignored.
  always_comb begin
    sel_done_c = 1'b0;
    case (size_q)
      2'd0:    sel_done_c = done8_i;
      2'd1:    sel_done_c = done16_i;
      2'd2:    sel_done_c = done32_i;
      default: sel_done_c = 1'b0;
    endcase
  end

  // Sequencer with all outputs registered alongside the state.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= IDLE;
      size_q      <= 2'd0;
      req_ready_o <= 1'b1;
      start8_o    <= 1'b0;
      start16_o   <= 1'b0;
      start32_o   <= 1'b0;
      oe8_o       <= 1'b0;
      oe16_o      <= 1'b0;
      oe32_o      <= 1'b0;
      res_valid_o <= 1'b0;
      res_size_o  <= 2'd0;
      busy_o      <= 1'b0;
      err_o       <= 1'b0;
      frame_cnt_o <= '0;
`ifdef FFT_CTRL_TIMEOUT_EN
      tmo_q       <= '0;
`endif
    end else begin
      start8_o  <= 1'b0;
      start16_o <= 1'b0;
      start32_o <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid_i) begin
            if (req_size_i == 2'd3) begin
              err_o <= 1'b1;
            end else begin
              size_q      <= req_size_i;
              state       <= START;
              req_ready_o <= 1'b0;
              busy_o      <= 1'b1;
              start8_o    <= (req_size_i == 2'd0);
              start16_o   <= (req_size_i == 2'd1);
              start32_o   <= (req_size_i == 2'd2);
              oe8_o       <= (req_size_i == 2'd0);
              oe16_o      <= (req_size_i == 2'd1);
              oe32_o      <= (req_size_i == 2'd2);
            end
          end
        end
        START: begin
          state <= WAIT;
`ifdef FFT_CTRL_TIMEOUT_EN
          tmo_q <= '0;
`endif
        end
        WAIT: begin
          if (sel_done_c) begin
            state       <= HOLD;
            res_valid_o <= 1'b1;
            res_size_o  <= size_q;
          end
`ifdef FFT_CTRL_TIMEOUT_EN
          else if (tmo_q == TMO_W'(TMO_CYCLES)) begin
            state       <= IDLE;
            err_o       <= 1'b1;
            oe8_o       <= 1'b0;
            oe16_o      <= 1'b0;
            oe32_o      <= 1'b0;
            busy_o      <= 1'b0;
            req_ready_o <= 1'b1;
          end else begin
            tmo_q <= tmo_q + TMO_W'(1);
          end
`endif
        end
        HOLD: begin
          if (res_ready_i) begin
            state       <= IDLE;
            frame_cnt_o <= frame_cnt_o + CNT_W'(1);
            res_valid_o <= 1'b0;
            res_size_o  <= 2'd0;
            oe8_o       <= 1'b0;
            oe16_o      <= 1'b0;
            oe32_o      <= 1'b0;
            busy_o      <= 1'b0;
            req_ready_o <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fft_size_ctrl.sv
// Directed + randomized bench for fft_size_ctrl; expectations come from a per-frame timeline model.
module tb_fft_size_ctrl;

  localparam int unsigned CNT_W = 4;
  localparam int unsigned TMO_W = 8;
  localparam int unsigned TMO   = 5;
  localparam int unsigned VW    = 12 + CNT_W;

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic             req_valid_i;
  logic [1:0]       req_size_i;
  logic             req_ready_o;
  logic             start8_o, start16_o, start32_o;
  logic             done8_i, done16_i, done32_i;
  logic             oe8_o, oe16_o, oe32_o;
  logic             res_valid_o;
  logic             res_ready_i;
  logic [1:0]       res_size_o;
  logic             busy_o;
  logic             err_o;
  logic [CNT_W-1:0] frame_cnt_o;

  fft_size_ctrl #(.CNT_W(CNT_W), .TMO_W(TMO_W), .TMO_CYCLES(TMO)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_size_i(req_size_i), .req_ready_o(req_ready_o),
    .start8_o(start8_o), .start16_o(start16_o), .start32_o(start32_o),
    .done8_i(done8_i), .done16_i(done16_i), .done32_i(done32_i),
    .oe8_o(oe8_o), .oe16_o(oe16_o), .oe32_o(oe32_o),
    .res_valid_o(res_valid_o), .res_ready_i(res_ready_i), .res_size_o(res_size_o),
    .busy_o(busy_o), .err_o(err_o), .frame_cnt_o(frame_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  int   checks = 0;
  int   errors = 0;
  int   m_cnt  = 0;
  logic m_err  = 1'b0;

  // Engine one-hot in {8,16,32} order.
  function automatic logic [2:0] onehot(input logic [1:0] s);
    case (s)
      2'd0:    return 3'b100;
      2'd1:    return 3'b010;
      2'd2:    return 3'b001;
      default: return 3'b000;
    endcase
  endfunction

  function automatic logic [VW-1:0] mk(input logic rr, input logic [2:0] st, input logic [2:0] oe,
                                       input logic rv, input logic [1:0] rs, input logic bz);
    return {rr, st, oe, rv, rs, bz, m_err, CNT_W'(m_cnt)};
  endfunction

  task automatic chk(input string tag, input logic [VW-1:0] exp);
    logic [VW-1:0] obs;
    obs = {req_ready_o, start8_o, start16_o, start32_o, oe8_o, oe16_o, oe32_o,
           res_valid_o, res_size_o, busy_o, err_o, frame_cnt_o};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic quiet();
    req_valid_i = 1'b0;
    req_size_i  = 2'd0;
    {done8_i, done16_i, done32_i} = 3'b000;
  endtask

  task automatic junk_req();
    req_valid_i = 1'($urandom);
    req_size_i  = 2'($urandom);
  endtask

  // One request from an idle negedge: done after d WAIT cycles, ready after r HOLD cycles.
  task automatic frame(input logic [1:0] s, input int d, input int r);
    logic [2:0] oh;
    logic [2:0] dn;
    bit         hit;
    oh  = onehot(s);
    hit = 0;
    req_valid_i = 1'b1;
    req_size_i  = s;
    {done8_i, done16_i, done32_i} = 3'b000;
    res_ready_i = 1'($urandom);
    @(negedge clk_i);
    if (s == 2'd3) begin
      m_err = 1'b1;
      quiet();
      chk("illegal_size", mk(1'b1, 3'b000, 3'b000, 1'b0, 2'd0, 1'b0));
      return;
    end
    chk("start", mk(1'b0, oh, oh, 1'b0, 2'd0, 1'b1));
    junk_req();
    {done8_i, done16_i, done32_i} = 3'b000;
    @(negedge clk_i);
    for (int w = 0; w < 64; w++) begin
      chk("wait", mk(1'b0, 3'b000, oh, 1'b0, 2'd0, 1'b1));
      dn = 3'($urandom) & ~oh;
      if (w == d) dn = dn | oh;
      {done8_i, done16_i, done32_i} = dn;
      res_ready_i = 1'($urandom);
      junk_req();
      @(negedge clk_i);
      if (w == d) begin
        hit = 1;
        break;
      end
`ifdef FFT_CTRL_TIMEOUT_EN
      if (w == int'(TMO)) begin
        m_err = 1'b1;
        quiet();
        chk("timeout_idle", mk(1'b1, 3'b000, 3'b000, 1'b0, 2'd0, 1'b0));
        return;
      end
`endif
    end
    checks++;
    assert (hit) else begin
      errors++;
      $error("FAIL wait_bound observed=%0d expected=1", hit);
    end
    for (int h = 0; h <= r; h++) begin
      chk("hold", mk(1'b0, 3'b000, oh, 1'b1, s, 1'b1));
      {done8_i, done16_i, done32_i} = 3'($urandom);
      res_ready_i = (h == r);
      junk_req();
      @(negedge clk_i);
    end
    m_cnt = (m_cnt + 1) % (1 << CNT_W);
    quiet();
    chk("after_handshake", mk(1'b1, 3'b000, 3'b000, 1'b0, 2'd0, 1'b0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int dmax;
`ifdef FFT_CTRL_TIMEOUT_EN
    dmax = int'(TMO) + 3;
`else
    dmax = 24;
`endif
    rst_i = 1'b1;
    quiet();
    res_ready_i = 1'b0;
    repeat (3) @(negedge clk_i);
    chk("reset_values", mk(1'b1, 3'b000, 3'b000, 1'b0, 2'd0, 1'b0));
    rst_i = 1'b0;
    @(negedge clk_i);
    chk("idle_after_reset", mk(1'b1, 3'b000, 3'b000, 1'b0, 2'd0, 1'b0));

    frame(2'd1, 19, 0);
    frame(2'd2, 4, 0);
    frame(2'd2, 3, 10);
    frame(2'd3, 0, 0);
    frame(2'd0, 2, 1);
`ifdef FFT_CTRL_TIMEOUT_EN
    frame(2'd0, int'(TMO) + 1, 0);
    frame(2'd1, int'(TMO), 0);
`endif

    for (int n = 0; n < 40; n++) begin
      frame(2'($urandom_range(0, 3)), int'($urandom_range(0, dmax)), int'($urandom_range(0, 3)));
      if ($urandom_range(0, 2) == 0) begin
        @(negedge clk_i);
        chk("idle_gap", mk(1'b1, 3'b000, 3'b000, 1'b0, 2'd0, 1'b0));
      end
    end

    // Abort a 32-point frame in WAIT, then deliver a stale done.
    req_valid_i = 1'b1;
    req_size_i  = 2'd2;
    @(negedge clk_i);
    quiet();
    repeat (2) @(negedge clk_i);
    chk("pre_abort_wait", mk(1'b0, 3'b000, 3'b001, 1'b0, 2'd0, 1'b1));
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
    m_cnt = 0;
    m_err = 1'b0;
    chk("abort_reset", mk(1'b1, 3'b000, 3'b000, 1'b0, 2'd0, 1'b0));
    done32_i = 1'b1;
    @(negedge clk_i);
    done32_i = 1'b0;
    chk("late_done_ignored", mk(1'b1, 3'b000, 3'b000, 1'b0, 2'd0, 1'b0));
    @(negedge clk_i);
    chk("still_idle", mk(1'b1, 3'b000, 3'b000, 1'b0, 2'd0, 1'b0));
    frame(2'd0, 1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fft_size_ctrl.md
Name: fft_size_ctrl

Overview:
- Sequences the three radix-2 engines (8/16/32-point) behind the shared OR-combining output mux.
- Accepts one transform request at a time with a size code and issues a one-cycle start pulse to the selected engine.
- Holds output-enable gating so non-selected engines drive zero into the OR mux, and waits for that engine's done.
- Presents the result to the consumer with a valid/ready handshake; counts completed frames.

Parameters:
- CNT_W, 16, width of the completed-frame counter.
- TMO_W, 8, width of the done-timeout counter.
- TMO_CYCLES, 200, cycles allowed between start pulse and engine done (must be < 2^TMO_W).

Ports:
- clk_i  input  1  clock, all logic rising-edge.
- rst_i  input  1  synchronous, active-high reset.
- req_valid_i  input  1  transform request.
- req_size_i  input  2  0=8-pt, 1=16-pt, 2=32-pt, 3=illegal.
- req_ready_o  output  1  controller can accept a request.
- start8_o / start16_o / start32_o  output  1 each  one-cycle engine start pulses.
- done8_i / done16_i / done32_i  input  1 each  engine completion pulses.
- oe8_o / oe16_o / oe32_o  output  1 each  engine output enables (engine drives zero when low).
- res_valid_o  output  1  mux output holds a valid result.
- res_ready_i  input  1  consumer accepts result.
- res_size_o  output  2  size code of the presented result.
- busy_o  output  1  high in any state other than IDLE.
- err_o  output  1  sticky error flag (illegal size or timeout).
- frame_cnt_o  output  CNT_W  completed, accepted frames.

Behaviour:
- Reset values:
  - req_ready_o=1; all other outputs 0.
  - FSM=IDLE; size register=0; counters=0.
  - rst_i mid-operation aborts the frame. No result is issued, and the engine receives no further start.
- FSM states: IDLE, START, WAIT, HOLD.
- IDLE
  - req_ready_o=1.
  - On req_valid_i with size 0..2: latch size, go to START.
  - On size 3: set err_o, stay in IDLE, accept nothing else (request consumed).
- START (exactly 1 cycle)
  - Assert the selected start pulse and the selected oe; clear the timeout counter; go to WAIT.
  - Start pulse appears 1 cycle after the accepting edge.
- WAIT
  - Selected oe held high; timeout counter increments every cycle.
  - Done from the selected engine: go to HOLD.
  - Done pulses from non-selected engines are ignored.
- HOLD
  - res_valid_o=1, res_size_o=latched size, oe held.
  - On res_valid_o && res_ready_i: frame_cnt_o++ (wraps at 2^CNT_W-1 -> 0), drop oe, go to IDLE.
  - res_valid_o must not drop before acceptance.
- Concurrency and gating:
  - req_ready_o is high only in IDLE, so there is no request overlap.
  - A new request may be accepted on the cycle after the handshake.
- At most one oe is high at any time; all oe are low in IDLE.
- start pulses are mutually exclusive and each lasts exactly 1 cycle.
- Latency: done in WAIT at cycle t gives res_valid_o=1 at t+1.
- err_o is sticky until rst_i.

Optional Feature:
- Macro: FFT_CTRL_TIMEOUT_EN.
- Defined:
  - In WAIT, when the timeout counter reaches TMO_CYCLES without the selected done, set err_o, drop oe, return to IDLE. No result is issued and frame_cnt_o is unchanged.
  - A done in the same cycle the count reaches TMO_CYCLES wins: go to HOLD.
- Undefined:
  - No timeout counter is instantiated; WAIT persists indefinitely; err_o is set only by an illegal size.

Test Plan:
- Size 1 request, done16 pulsed 20 cycles after start16, res_ready_i held high:
  - start16_o for 1 cycle.
  - oe16_o high from START until the handshake.
  - res_valid_o 1 cycle after done16, res_size_o=1, frame_cnt_o=1.
- Size 2 request, done8_i and done16_i pulsed during WAIT:
  - Both ignored, stays in WAIT.
  - done32 then gives HOLD.
  - oe8_o and oe16_o never high.
- HOLD with res_ready_i low for 10 cycles:
  - res_valid_o and oe32_o stay stable.
  - req_ready_o=0 and a new req_valid_i is not accepted.
  - Release ready: count +1, req_ready_o=1 next cycle.
- req_size_i=3:
  - err_o=1, no start pulse, FSM stays IDLE.
  - A subsequent size 0 request still completes normally with err_o still 1.
- With FFT_CTRL_TIMEOUT_EN and TMO_CYCLES=5, no done:
  - err_o set, oe dropped, back in IDLE, frame_cnt_o unchanged.
  - Repeat with done exactly at count 5: goes to HOLD instead.
- rst_i asserted in WAIT for 1 cycle:
  - Next cycle all outputs at reset values.
  - A late done pulse is ignored.
  - frame_cnt_o=0.
